// File: rtl/if_stage_if.sv
// Bus bundle between the instruction-fetch stage and its surroundings:
// instruction memory, decode handshake, redirect request, IF/ID register
// contents, misaligned-target exception and the debug fetch counter.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        exc_misaligned;
  logic [31:0] exc_addr;
  logic [31:0] fetch_count;

  // Fetch stage side.
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  id_ready,
    input  redirect,
    input  redirect_pc,
    output if_id_instr,
    output if_id_pc,
    output if_id_pc4,
    output if_id_valid,
    output exc_misaligned,
    output exc_addr,
    output fetch_count
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output id_ready,
    output redirect,
    output redirect_pc,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_pc4,
    input  if_id_valid,
    input  exc_misaligned,
    input  exc_addr,
    input  fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the asynchronous instruction
// memory and fills the IF/ID pipeline register. Each cycle resolves, in
// order, redirect > stall > advance; reset overrides everything. A redirect
// always flushes IF/ID to a NOP bubble, and a non-word-aligned target raises
// a one-cycle exception pulse instead of moving the PC.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic      clk,
  input  logic      rst_n,
  if_stage_if.master bus
);

  // Word alignment check for redirect targets.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  logic [31:0] pc_r,       pc_s;
  logic [31:0] instr_r,    instr_s;
  logic [31:0] id_pc_r,    id_pc_s;
  logic [31:0] id_pc4_r,   id_pc4_s;
  logic        valid_r,    valid_s;
  logic        exc_r,      exc_s;
  logic [31:0] exc_addr_r, exc_addr_s;
  logic [31:0] count_r,    count_s;
  logic [31:0] pc_plus4_s;

  // The memory address is the PC register itself, so it never depends on
  // id_ready or redirect in the same cycle.
  assign bus.imem_addr      = pc_r;
  assign bus.if_id_instr    = instr_r;
  assign bus.if_id_pc       = id_pc_r;
  assign bus.if_id_pc4      = id_pc4_r;
  assign bus.if_id_valid    = valid_r;
  assign bus.exc_misaligned = exc_r;
  assign bus.exc_addr       = exc_addr_r;
  assign bus.fetch_count    = count_r;

  // Sequential PC increment; wraps modulo 2^32 with no flag.
  assign pc_plus4_s = pc_r + 32'd4;

  // Next-state selection: redirect beats stall, stall beats advance.
  always_comb begin
    pc_s       = pc_r;
    instr_s    = instr_r;
    id_pc_s    = id_pc_r;
    id_pc4_s   = id_pc4_r;
    valid_s    = valid_r;
    exc_s      = 1'b0;
    exc_addr_s = exc_addr_r;
    count_s    = count_r;
    if (bus.redirect) begin
      // Flush IF/ID; if_id_pc/pc4 keep their last values under the bubble.
      instr_s = NOP_INSTR;
      valid_s = 1'b0;
      if (is_word_aligned(bus.redirect_pc)) begin
        pc_s = bus.redirect_pc;
      end else begin
        exc_s      = 1'b1;
        exc_addr_s = bus.redirect_pc;
      end
    end else if (bus.id_ready) begin
      instr_s  = bus.imem_rdata;
      id_pc_s  = pc_r;
      id_pc4_s = pc_plus4_s;
      valid_s  = 1'b1;
      pc_s     = pc_plus4_s;
      count_s  = count_r + 32'd1;
    end else begin
      // Stall: everything holds (defaults above).
      pc_s = pc_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      instr_r    <= NOP_INSTR;
      id_pc_r    <= 32'h0000_0000;
      id_pc4_r   <= 32'h0000_0000;
      valid_r    <= 1'b0;
      exc_r      <= 1'b0;
      exc_addr_r <= 32'h0000_0000;
      count_r    <= 32'h0000_0000;
    end else begin
      pc_r       <= pc_s;
      instr_r    <= instr_s;
      id_pc_r    <= id_pc_s;
      id_pc4_r   <= id_pc4_s;
      valid_r    <= valid_s;
      exc_r      <= exc_s;
      exc_addr_r <= exc_addr_s;
      count_r    <= count_s;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, free-run, stall, aligned and
// misaligned redirects, PC wrap, back-to-back redirects and reset during a
// redirect. Expected values are hand-computed constants.
module tb_if_stage;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words, tagged address elsewhere.
  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0011_8133;
      32'h0000_0004: return 32'h0020_8193;
      default:       return {16'hC0DE, addr[15:0]};
    endcase
  endfunction

  // Asynchronous memory read.
  always_comb bus.imem_rdata = imem_word(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n           = 1'b0;
    bus.id_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0000_0000;

    // Reset for two cycles.
    step();
    step();
    chk("rst_valid",    {31'd0, bus.if_id_valid},    32'd0);
    chk("rst_instr",    bus.if_id_instr,             32'h0000_0013);
    chk("rst_pc",       bus.if_id_pc,                32'h0000_0000);
    chk("rst_pc4",      bus.if_id_pc4,               32'h0000_0000);
    chk("rst_exc",      {31'd0, bus.exc_misaligned}, 32'd0);
    chk("rst_exc_addr", bus.exc_addr,                32'h0000_0000);
    chk("rst_count",    bus.fetch_count,             32'd0);
    chk("rst_imem",     bus.imem_addr,               32'h0000_0000);
    rst_n = 1'b1;

    // Free-run.
    step();
    chk("run0_pc",    bus.if_id_pc,                32'h0000_0000);
    chk("run0_instr", bus.if_id_instr,             32'h0011_8133);
    chk("run0_valid", {31'd0, bus.if_id_valid},    32'd1);
    chk("run0_pc4",   bus.if_id_pc4,               32'h0000_0004);
    chk("run0_count", bus.fetch_count,             32'd1);
    step();
    chk("run1_pc",    bus.if_id_pc,                32'h0000_0004);
    chk("run1_instr", bus.if_id_instr,             32'h0020_8193);
    chk("run1_count", bus.fetch_count,             32'd2);
    step();
    chk("run2_pc",    bus.if_id_pc,                32'h0000_0008);
    chk("run2_instr", bus.if_id_instr,             32'hC0DE_0008);
    chk("run2_imem",  bus.imem_addr,               32'h0000_000C);
    chk("run2_count", bus.fetch_count,             32'd3);

    // Stall three cycles while if_id_pc=0x8.
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc",    bus.if_id_pc,             32'h0000_0008);
      chk("stall_instr", bus.if_id_instr,          32'hC0DE_0008);
      chk("stall_valid", {31'd0, bus.if_id_valid}, 32'd1);
      chk("stall_imem",  bus.imem_addr,            32'h0000_000C);
      chk("stall_count", bus.fetch_count,          32'd3);
    end
    bus.id_ready = 1'b1;
    step();
    chk("resume_pc",    bus.if_id_pc,    32'h0000_000C);
    chk("resume_instr", bus.if_id_instr, 32'hC0DE_000C);
    chk("resume_count", bus.fetch_count, 32'd4);
    chk("resume_imem",  bus.imem_addr,   32'h0000_0010);

    // Aligned redirect during a stall.
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    step();
    chk("redir_valid", {31'd0, bus.if_id_valid},    32'd0);
    chk("redir_instr", bus.if_id_instr,             32'h0000_0013);
    chk("redir_imem",  bus.imem_addr,               32'h0000_0100);
    chk("redir_pchld", bus.if_id_pc,                32'h0000_000C);
    chk("redir_count", bus.fetch_count,             32'd4);
    chk("redir_exc",   {31'd0, bus.exc_misaligned}, 32'd0);
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    step();
    chk("tgt_pc",    bus.if_id_pc,             32'h0000_0100);
    chk("tgt_valid", {31'd0, bus.if_id_valid}, 32'd1);
    chk("tgt_instr", bus.if_id_instr,          32'hC0DE_0100);
    chk("tgt_pc4",   bus.if_id_pc4,            32'h0000_0104);
    chk("tgt_count", bus.fetch_count,          32'd5);

    // Misaligned redirect.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    step();
    chk("mis_exc",      {31'd0, bus.exc_misaligned}, 32'd1);
    chk("mis_exc_addr", bus.exc_addr,                32'h0000_0102);
    chk("mis_imem",     bus.imem_addr,               32'h0000_0104);
    chk("mis_valid",    {31'd0, bus.if_id_valid},    32'd0);
    chk("mis_instr",    bus.if_id_instr,             32'h0000_0013);
    chk("mis_count",    bus.fetch_count,             32'd5);
    bus.redirect = 1'b0;
    step();
    chk("mis_pulse",    {31'd0, bus.exc_misaligned}, 32'd0);
    chk("mis_addr_hld", bus.exc_addr,                32'h0000_0102);
    chk("mis_next_pc",  bus.if_id_pc,                32'h0000_0104);
    chk("mis_next_vld", {31'd0, bus.if_id_valid},    32'd1);
    chk("mis_next_cnt", bus.fetch_count,             32'd6);

    // Wrap at the top of the address space.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_redir_imem", bus.imem_addr,               32'hFFFF_FFFC);
    chk("wrap_redir_exc",  {31'd0, bus.exc_misaligned}, 32'd0);
    bus.redirect = 1'b0;
    step();
    chk("wrap_pc",    bus.if_id_pc,                32'hFFFF_FFFC);
    chk("wrap_pc4",   bus.if_id_pc4,               32'h0000_0000);
    chk("wrap_instr", bus.if_id_instr,             32'hC0DE_FFFC);
    chk("wrap_imem",  bus.imem_addr,               32'h0000_0000);
    chk("wrap_exc",   {31'd0, bus.exc_misaligned}, 32'd0);
    chk("wrap_count", bus.fetch_count,             32'd7);

    // Back-to-back redirects: the last one wins.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step();
    bus.redirect_pc = 32'h0000_0300;
    step();
    chk("b2b_imem",  bus.imem_addr,             32'h0000_0300);
    chk("b2b_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("b2b_count", bus.fetch_count,          32'd7);
    bus.redirect = 1'b0;
    step();
    chk("b2b_pc",    bus.if_id_pc,    32'h0000_0300);
    chk("b2b_instr", bus.if_id_instr, 32'hC0DE_0300);

    // Reset together with a redirect: redirect ignored.
    rst_n           = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step();
    chk("mrst_imem",     bus.imem_addr,            32'h0000_0000);
    chk("mrst_valid",    {31'd0, bus.if_id_valid}, 32'd0);
    chk("mrst_count",    bus.fetch_count,          32'd0);
    chk("mrst_instr",    bus.if_id_instr,          32'h0000_0013);
    chk("mrst_exc_addr", bus.exc_addr,             32'h0000_0000);
    rst_n        = 1'b1;
    bus.redirect = 1'b0;
    step();
    chk("post_pc",    bus.if_id_pc,    32'h0000_0000);
    chk("post_instr", bus.if_id_instr, 32'h0011_8133);
    chk("post_count", bus.fetch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
